// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and saturation helper for the linear CORDIC
// blocks (multiplier here, reciprocal later).
package cordic_pkg;

  localparam int WORD_LENGTH_DEF       = 18;
  localparam int FRAC_LENGTH_DEF       = 11;
  localparam int NUM_OF_ITERATIONS_DEF = 11;
  localparam int SCALE_DEF             = 5;

  localparam logic [WORD_LENGTH_DEF-1:0] one_fixed_point  =
    {{(WORD_LENGTH_DEF-1){1'b0}}, 1'b1} << FRAC_LENGTH_DEF;
  localparam logic [WORD_LENGTH_DEF-1:0] half_fixed_point =
    {{(WORD_LENGTH_DEF-1){1'b0}}, 1'b1} << (FRAC_LENGTH_DEF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    FINISH  = 2'd2
  } cordic_state_e;

  // Clamp a sign-extended wide value to the signed range of 'width' bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int unsigned width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/cordic_linear_stage.sv
// Combinational linear-mode micro-rotation: steers Z toward zero by one
// binary step and moves Y by the matching shifted copy of A.
module cordic_linear_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH       = WORD_LENGTH_DEF + 2,
  parameter int FRAC_LENGTH = FRAC_LENGTH_DEF,
  parameter int ITER_WIDTH  = 4
) (
  input  logic signed [WIDTH-1:0]      y_i,
  input  logic signed [WIDTH-1:0]      z_i,
  input  logic signed [WIDTH-1:0]      a_i,
  input  logic        [ITER_WIDTH-1:0] iter_i,
  output logic signed [WIDTH-1:0]      y_next_o,
  output logic signed [WIDTH-1:0]      z_next_o
);

  localparam logic signed [WIDTH-1:0] ONE_FP = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC_LENGTH;

  logic signed [WIDTH-1:0] a_shift;
  logic signed [WIDTH-1:0] step;

  always_comb begin
    a_shift  = a_i >>> iter_i;
    step     = ONE_FP >> iter_i;
    y_next_o = y_i;
    z_next_o = z_i;
    // A residual of exactly zero is final; no further rotation direction exists.
    if (z_i != '0) begin
      if (z_i[WIDTH-1]) begin
        y_next_o = y_i - a_shift;
        z_next_o = z_i + step;
      end else begin
        y_next_o = y_i + a_shift;
        z_next_o = z_i - step;
      end
    end
  end

endmodule

// File: rtl/linear_cordic_multiplier.sv
// Iterative linear-rotation CORDIC multiplier: Product = sat(Multiplicand * Multiplier),
// one micro-rotation per clock, with range reduction of large multipliers.
module linear_cordic_multiplier
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH       = WORD_LENGTH_DEF,
  parameter int FRAC_LENGTH       = FRAC_LENGTH_DEF,
  parameter int NUM_OF_ITERATIONS = NUM_OF_ITERATIONS_DEF,
  parameter int SCALE             = SCALE_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Enable,
  input  logic signed [WORD_LENGTH-1:0] Multiplicand,
  input  logic signed [WORD_LENGTH-1:0] Multiplier,
  output logic signed [WORD_LENGTH-1:0] Product,
  output logic                          Valid,
  output logic                          Busy,
  output cordic_state_e                 dbg_state_o
);

  // Handshake: Enable is a start strobe sampled only while Busy=0; Valid is a
  // single-cycle pulse and Product holds until the next result is produced.

  localparam int YW         = WORD_LENGTH + 2;
  localparam int RW         = WORD_LENGTH + SCALE + 2;
  localparam int ITER_WIDTH = $clog2(NUM_OF_ITERATIONS + 1);
  localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(NUM_OF_ITERATIONS);
  localparam logic signed [WORD_LENGTH-1:0] ONE_W =
    {{(WORD_LENGTH-1){1'b0}}, 1'b1} << FRAC_LENGTH;
  localparam logic signed [WORD_LENGTH-1:0] NEG_ONE_W = -ONE_W;

  cordic_state_e               state_q,   state_d;
  logic [ITER_WIDTH-1:0]       iter_q,    iter_d;
  logic signed [YW-1:0]        y_q,       y_d;
  logic signed [YW-1:0]        z_q,       z_d;
  logic signed [YW-1:0]        a_q,       a_d;
  logic                        scale_q,   scale_d;
  logic signed [WORD_LENGTH-1:0] product_q, product_d;
  logic                        valid_q,   valid_d;
  logic                        busy_q,    busy_d;

  logic signed [YW-1:0] y_next;
  logic signed [YW-1:0] z_next;
  logic signed [RW-1:0] r_wide;
  logic                 big_mult;

  // The most-negative code also lands here, so it is always range-reduced.
  assign big_mult = (Multiplier >= ONE_W) || (Multiplier <= NEG_ONE_W);

  cordic_linear_stage #(
    .WIDTH       (YW),
    .FRAC_LENGTH (FRAC_LENGTH),
    .ITER_WIDTH  (ITER_WIDTH)
  ) u_stage (
    .y_i      (y_q),
    .z_i      (z_q),
    .a_i      (a_q),
    .iter_i   (iter_q),
    .y_next_o (y_next),
    .z_next_o (z_next)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      y_q       <= '0;
      z_q       <= '0;
      a_q       <= '0;
      scale_q   <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      y_q       <= y_d;
      z_q       <= z_d;
      a_q       <= a_d;
      scale_q   <= scale_d;
      product_q <= product_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    y_d       = y_q;
    z_d       = z_q;
    a_d       = a_q;
    scale_d   = scale_q;
    product_d = product_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    r_wide    = '0;
    unique case (state_q)
      IDLE: begin
        if (Enable) begin
          state_d = ITERATE;
          a_d     = YW'(Multiplicand);
          y_d     = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          if (big_mult) begin
            z_d     = YW'(Multiplier >>> SCALE);
            scale_d = 1'b1;
          end else begin
            z_d     = YW'(Multiplier);
            scale_d = 1'b0;
          end
        end
      end
      ITERATE: begin
        y_d = y_next;
        z_d = z_next;
        if (iter_q == LAST_ITER) begin
          state_d = FINISH;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      FINISH: begin
        // Undo the range reduction before clamping back to the I/O width.
        r_wide    = scale_q ? (RW'(y_q) <<< SCALE) : RW'(y_q);
        product_d = WORD_LENGTH'(saturate(64'(r_wide), WORD_LENGTH));
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Product     = product_q;
  assign Valid       = valid_q;
  assign Busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
